// File: rtl/systolic_array_ctrl.sv
// Sequencer for the 8x8 weight-stationary systolic array: weight load, vector stepping, result read-out.
// Latency: ROWS load cycles + LAT fill steps, then 3 cycles per result vector (STEP, RD_LO, RD_HI).
// Backpressure: a low out_ready holds RD_LO/RD_HI with the array frozen (enable_cycle=0).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, num_vectors       tile launch pulse and vector count (sampled in IDLE)
//   abort                    synchronous return to IDLE, no done
//   busy, done               tile in progress / 1-cycle completion pulse
//   w_rd_en, w_rd_addr       weight buffer read port (rows issued last-first)
//   pix_rd_en, pix_rd_addr   pixel buffer read port (low enable feeds zeros)
//   enable_cycle, load_W     array step enable and weight-load mode
//   output_group_sel         array output mux: 0 = cols 0-3, 1 = cols 4-7
//   res_valid, res_half,     half-result stream towards the consumer
//   res_index, out_ready
module systolic_array_ctrl #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int CNT_WIDTH = 16,
  parameter int LAT       = ROWS + COLS - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_WIDTH-1:0]          num_vectors,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          w_rd_en,
  output logic [$clog2(ROWS)-1:0]       w_rd_addr,
  output logic                          pix_rd_en,
  output logic [CNT_WIDTH-1:0]          pix_rd_addr,
  output logic                          enable_cycle,
  output logic                          load_W,
  output logic                          output_group_sel,
  output logic                          res_valid,
  output logic                          res_half,
  output logic [CNT_WIDTH-1:0]          res_index,
  input  logic                          out_ready
);

  localparam int KW = $clog2(ROWS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_RD_LO = 3'd3;
  localparam logic [2:0] S_RD_HI = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_WIDTH-1:0] LAT_C  = CNT_WIDTH'(LAT);
  // Largest N for which N + LAT still fits the step counter.
  localparam logic [CNT_WIDTH-1:0] N_MAX  = {CNT_WIDTH{1'b1}} - LAT_C;
  localparam logic [KW-1:0]        K_LAST = KW'(ROWS - 1);

  logic [2:0]           state;
  logic [CNT_WIDTH-1:0] s;      // step counter, 0..S-1
  logic [CNT_WIDTH-1:0] n;      // latched vector count
  logic [KW-1:0]        k;      // weight row counter

  logic [CNT_WIDTH-1:0] n_sat;
  logic [CNT_WIDTH-1:0] s_total;
  logic [CNT_WIDTH-1:0] s_inc;

  assign n_sat   = (num_vectors > N_MAX) ? N_MAX : num_vectors;
  assign s_total = n + LAT_C;
  assign s_inc   = s + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      s     <= '0;
      n     <= '0;
      k     <= '0;
    end else if (abort) begin
      // Abort wins over everything, including a start seen in IDLE.
      state <= S_IDLE;
      s     <= '0;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n     <= n_sat;
            s     <= '0;
            k     <= '0;
            state <= (num_vectors == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_STEP;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_STEP: begin
          // Once the pipeline is full, every step is followed by a two-half read
          // of the result that step pushed out; s advances only after the read.
          if (s >= LAT_C) begin
            state <= S_RD_LO;
          end else begin
            s     <= s_inc;
            state <= (s_inc == s_total) ? S_DONE : S_STEP;
          end
        end
        S_RD_LO: begin
          if (out_ready) state <= S_RD_HI;
        end
        S_RD_HI: begin
          if (out_ready) begin
            s     <= s_inc;
            state <= (s_inc == s_total) ? S_DONE : S_STEP;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // All outputs decode from state and counters only; none depends on out_ready.
  assign busy             = (state == S_LOAD) || (state == S_STEP) ||
                            (state == S_RD_LO) || (state == S_RD_HI);
  assign done             = (state == S_DONE);
  assign load_W           = (state == S_LOAD);
  assign w_rd_en          = (state == S_LOAD);
  assign w_rd_addr        = (state == S_LOAD) ? (K_LAST - k) : '0;
  assign enable_cycle     = (state == S_LOAD) || (state == S_STEP);
  assign pix_rd_en        = (state == S_STEP) && (s < n);
  assign pix_rd_addr      = pix_rd_en ? s : '0;
  assign res_valid        = (state == S_RD_LO) || (state == S_RD_HI);
  assign output_group_sel = (state == S_RD_HI);
  assign res_half         = (state == S_RD_HI);
  assign res_index        = res_valid ? (s - LAT_C) : '0;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
module tb_systolic_array_ctrl;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_vectors;
  logic          abort;
  logic          out_ready;
  logic          busy, done, w_rd_en, pix_rd_en, enable_cycle, load_W;
  logic          output_group_sel, res_valid, res_half;
  logic [2:0]    w_rd_addr;
  logic [CW-1:0] pix_rd_addr, res_index;

  systolic_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors), .abort(abort),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .enable_cycle(enable_cycle),
    .load_W(load_W), .output_group_sel(output_group_sel), .res_valid(res_valid),
    .res_half(res_half), .res_index(res_index), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboards: expected weight addresses, pixel addresses, and {index, half} results.
  int wq[$];
  int pq[$];
  int rq[$];

  int   busy_cnt, done_cnt, hs_cnt, stall_cnt, en_cnt, rv_cnt;
  logic prev_busy;
  logic exp_prev_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {20'b0, busy, done, w_rd_en, w_rd_addr, pix_rd_en, pix_rd_addr, enable_cycle,
            load_W, output_group_sel, res_valid, res_half, res_index};
  endfunction

  // Monitor: samples on the falling edge, pops the scoreboards as the DUT produces.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (enable_cycle) en_cnt++;
      if (done) begin
        done_cnt++;
        check("done_busy_low", 64'(busy), 64'(0));
        check("done_after_busy", 64'(prev_busy), 64'(exp_prev_busy));
      end
      if (w_rd_en) begin
        check("w_mode", 64'({load_W, enable_cycle}), 64'(2'b11));
        if (wq.size() == 0) check("w_unexpected", 64'(w_rd_en), 64'(0));
        else check("w_addr", 64'(w_rd_addr), 64'(wq.pop_front()));
      end
      if (pix_rd_en) begin
        check("pix_mode", 64'({enable_cycle, load_W}), 64'(2'b10));
        if (pq.size() == 0) check("pix_unexpected", 64'(pix_rd_en), 64'(0));
        else check("pix_addr", 64'(pix_rd_addr), 64'(pq.pop_front()));
      end
      if (res_valid) begin
        rv_cnt++;
        check("rd_frozen", 64'(enable_cycle), 64'(0));
        check("sel_eq_half", 64'(output_group_sel), 64'(res_half));
        if (rq.size() == 0) check("res_unexpected", 64'(res_valid), 64'(0));
        else begin
          check("res_idx_half", 64'({res_index, res_half}), 64'(rq[0]));
          if (out_ready) begin
            void'(rq.pop_front());
            hs_cnt++;
          end else begin
            stall_cnt++;
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0; hs_cnt = 0; stall_cnt = 0; en_cnt = 0; rv_cnt = 0;
    wq.delete(); pq.delete(); rq.delete();
  endtask

  // Drive a start pulse and push everything the tile should produce.
  task automatic start_tile(input int n, input bit expect_run);
    num_vectors = CW'(n);
    start = 1'b1;
    if (expect_run && n > 0) begin
      for (int r = ROWS - 1; r >= 0; r--) wq.push_back(r);
      for (int i = 0; i < n; i++) begin
        pq.push_back(i);
        rq.push_back(i * 2);
        rq.push_back(i * 2 + 1);
      end
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      tick();
      cyc++;
    end
    check("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic wait_res1_lo(input int budget);
    int c;
    c = 0;
    while (!(res_valid && res_index == 16'd1 && !res_half) && c < budget) begin
      tick();
      c++;
    end
    check("stall_reach", 64'({res_valid, res_index, res_half}), 64'({1'b1, 16'd1, 1'b0}));
  endtask

  task automatic tile_end(input string tag, input int exp_busy, input int exp_hs);
    tick();
    tick();
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    check({tag, "_handshakes"}, 64'(hs_cnt), 64'(exp_hs));
    check({tag, "_sb_left"}, 64'(wq.size() + pq.size() + rq.size()), 64'(0));
  endtask

  initial begin
    int cyc;
    int b0;
    rst = 1'b1; start = 1'b0; num_vectors = '0; abort = 1'b0; out_ready = 1'b1;
    prev_busy = 1'b0; exp_prev_busy = 1'b1;
    clear_stats();
    repeat (2) @(posedge clk);
    #2;
    check("reset_outs", all_outs(), 64'(0));
    rst = 1'b0;
    tick();

    // Reset in the middle of the weight load.
    clear_stats();
    start_tile(4, 1'b1);
    tick(); tick(); tick();
    check("load_k3_addr", 64'(w_rd_addr), 64'(4));
    rst = 1'b1;
    #1;
    check("rst_async_outs", all_outs(), 64'(0));
    tick();
    check("rst_hold_outs", all_outs(), 64'(0));
    rst = 1'b0;
    tick();

    // Full tile after reset: weights reload 7..0, busy = 8 + 14 + 3*4.
    clear_stats();
    exp_prev_busy = 1'b1;
    start_tile(4, 1'b1);
    wait_done(200, cyc);
    tile_end("n4", 34, 8);
    check("n4_stalls", 64'(stall_cnt), 64'(0));

    // Stall 5 cycles at RD_LO of index 1.
    clear_stats();
    start_tile(4, 1'b1);
    wait_res1_lo(200);
    out_ready = 1'b0;
    repeat (5) tick();
    check("stall_hold", 64'({res_valid, res_index, res_half, enable_cycle}),
          64'({1'b1, 16'd1, 1'b0, 1'b0}));
    out_ready = 1'b1;
    wait_done(200, cyc);
    tile_end("stall", 39, 8);
    check("stall_cycles", 64'(stall_cnt), 64'(5));

    // Empty tile: done immediately, nothing else moves.
    clear_stats();
    exp_prev_busy = 1'b0;
    start_tile(0, 1'b1);
    wait_done(5, cyc);
    check("n0_latency", 64'(cyc), 64'(0));
    tick(); tick();
    check("n0_busy", 64'(busy_cnt), 64'(0));
    check("n0_enable", 64'(en_cnt), 64'(0));
    check("n0_res_valid", 64'(rv_cnt), 64'(0));
    check("n0_done_count", 64'(done_cnt), 64'(1));

    // Abort during STEP, then start and abort together in IDLE.
    clear_stats();
    exp_prev_busy = 1'b1;
    start_tile(10, 1'b1);
    cyc = 0;
    while (!(enable_cycle && !load_W) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("abort_reach_step", 64'({enable_cycle, load_W}), 64'(2'b10));
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outs", all_outs(), 64'(0));
    wq.delete(); pq.delete(); rq.delete();
    repeat (20) tick();
    check("abort_no_done", 64'(done_cnt), 64'(0));
    b0 = busy_cnt;
    num_vectors = 16'd4;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (20) tick();
    check("start_abort_busy", 64'(busy_cnt), 64'(b0));
    check("start_abort_done", 64'(done_cnt), 64'(0));

    // Start pulses while busy are ignored.
    clear_stats();
    exp_prev_busy = 1'b1;
    start_tile(3, 1'b1);
    tick(); tick();
    num_vectors = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("busy_start_reach_rd", 64'(res_valid), 64'(1));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300, cyc);
    tile_end("busy_start", 31, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
